// File: rtl/power_window_sampler.sv
// power_window_sampler: samples the free-running accumulator once per window,
// queues each window's energy increment in a FIFO, and lets software drain it
// through a small register slave with a one-cycle read latency.
module power_window_sampler #(
    parameter int ACC_W = 36,
    parameter int CNT_W = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ACC_W-1:0] result_in,
    input  logic             run,
    input  logic [CNT_W-1:0] period,
    input  logic             s_read,
    input  logic             s_write,
    input  logic [2:0]       s_addr,
    input  logic [31:0]      s_wdata,
    output logic [31:0]      s_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             load;
    logic             count_down;
    logic             window_end;

    logic [ACC_W-1:0] prev;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] delta;

    logic [ACC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic [63:0]      head;

    logic [15:0]      drop_cnt;
    logic [31:0]      win_cnt;
    logic             ovf;

    logic             clear;
    logic             pop;
    logic             push_ok;
    logic             drop;
    logic             unused_wdata;

    assign delta        = result_in - prev;
    assign empty        = (count == '0);
    assign full         = (count == FULL_COUNT);
    assign head         = 64'(mem[rd_ptr]);
    assign clear        = s_write && (s_addr == 3'd0) && s_wdata[0];
    assign pop          = s_read && (s_addr == 3'd2) && !empty;
    assign push_ok      = window_end && (!full || pop);
    assign drop         = window_end && full && !pop;
    assign unused_wdata = ^s_wdata[31:1];

    // Window FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the reload / countdown / window-end strobes.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        count_down = 1'b0;
        window_end = 1'b0;
        case (state)
            IDLE: begin
                if (run && (period != '0)) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (!run || (period == '0)) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    load       = 1'b1;
                    window_end = 1'b1;
                end else begin
                    count_down = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Window baseline and period countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= '0;
            cnt  <= '0;
        end else if (load) begin
            prev <= result_in;
            cnt  <= period - CNT_ONE;
        end else if (count_down) begin
            cnt  <= cnt - CNT_ONE;
        end
    end

    // FIFO storage; a pop at full frees the slot the push overwrites.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[wr_ptr] <= delta;
        end
    end

    // FIFO pointers, occupancy and the statistics counters; clear beats everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            win_cnt  <= '0;
            ovf      <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            win_cnt  <= '0;
            ovf      <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (window_end) begin
                win_cnt <= win_cnt + 32'd1;
            end
            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

    // Registered read port; returns values as they were before this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_rdata <= '0;
        end else if (s_read) begin
            case (s_addr)
                3'd0:    s_rdata <= {16'd0, 8'(count), 4'd0, ovf, full, empty, state == RUN};
                3'd1:    s_rdata <= empty ? 32'd0 : head[31:0];
                3'd2:    s_rdata <= empty ? 32'd0 : head[63:32];
                3'd3:    s_rdata <= {16'd0, drop_cnt};
                3'd4:    s_rdata <= win_cnt;
                default: s_rdata <= 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_power_window_sampler.sv
// Directed testbench for power_window_sampler with hand-computed expectations.
module tb_power_window_sampler;

    logic        clk;
    logic        reset;
    logic [35:0] result_in;
    logic        run;
    logic [31:0] period;
    logic        s_read;
    logic        s_write;
    logic [2:0]  s_addr;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;

    logic        ramp_on;
    logic [35:0] ramp_step;
    logic [35:0] ramp_inc;
    logic [31:0] rd;
    int          checks;
    int          errors;

    power_window_sampler #(
        .ACC_W(36),
        .CNT_W(32),
        .DEPTH(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .result_in(result_in),
        .run      (run),
        .period   (period),
        .s_read   (s_read),
        .s_write  (s_write),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_rdata  (s_rdata)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and log any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One clock: inputs change 1 ns after the edge; the accumulator ramps if enabled.
    task automatic tick;
        @(posedge clk);
        #1;
        if (ramp_on) begin
            result_in = result_in + ramp_step;
            ramp_step = ramp_step + ramp_inc;
        end
    endtask

    // Set the window controls.
    task automatic applyStimulus(input logic run_v, input logic [31:0] period_v);
        run    = run_v;
        period = period_v;
    endtask

    // Single-cycle register read; data is valid after the edge.
    task automatic readReg(input logic [2:0] addr, output logic [31:0] data);
        s_read = 1'b1;
        s_addr = addr;
        tick();
        s_read = 1'b0;
        data   = s_rdata;
    endtask

    // Clear write to address 0.
    task automatic writeClear;
        s_write = 1'b1;
        s_addr  = 3'd0;
        s_wdata = 32'd1;
        tick();
        s_write = 1'b0;
        s_wdata = 32'd0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        result_in = '0;
        run       = 1'b0;
        period    = '0;
        s_read    = 1'b0;
        s_write   = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        ramp_on   = 1'b0;
        ramp_step = '0;
        ramp_inc  = '0;

        // Reset state.
        tick();
        tick();
        checkOutput("reset_rdata", 64'(s_rdata), 64'h0);
        reset = 1'b0;
        readReg(3'd0, rd); checkOutput("reset_status", 64'(rd), 64'h2);
        readReg(3'd4, rd); checkOutput("reset_wincnt", 64'(rd), 64'h0);

        // Ramp +3 per cycle, period 4: every delta is 12.
        result_in = 36'd100;
        ramp_step = 36'd3;
        ramp_inc  = 36'd0;
        ramp_on   = 1'b1;
        applyStimulus(1'b1, 32'd4);
        for (int i = 0; i < 21; i++) begin
            if (i == 10) begin
                readReg(3'd0, rd);
                checkOutput("ramp_status_mid", 64'(rd), 64'h201);
            end else begin
                tick();
            end
        end
        applyStimulus(1'b0, 32'd4);
        tick();
        ramp_on = 1'b0;
        readReg(3'd4, rd); checkOutput("ramp_wincnt", 64'(rd), 64'd5);
        readReg(3'd3, rd); checkOutput("ramp_drop", 64'(rd), 64'd0);
        readReg(3'd0, rd); checkOutput("ramp_status", 64'(rd), 64'h500);
        for (int i = 0; i < 5; i++) begin
            readReg(3'd1, rd); checkOutput("ramp_dlo", 64'(rd), 64'd12);
            readReg(3'd2, rd); checkOutput("ramp_dhi", 64'(rd), 64'd0);
        end
        readReg(3'd0, rd); checkOutput("ramp_drained", 64'(rd), 64'h2);

        // Modulo wrap of the accumulator, then a delta with non-zero upper bits.
        result_in = 36'hF_FFFF_FFFE;
        applyStimulus(1'b1, 32'd1);
        tick();
        result_in = 36'h0_0000_0004;
        tick();
        result_in = 36'h7_1234_5678;
        tick();
        applyStimulus(1'b0, 32'd1);
        tick();
        readReg(3'd1, rd); checkOutput("wrap_dlo", 64'(rd), 64'd6);
        readReg(3'd2, rd); checkOutput("wrap_dhi", 64'(rd), 64'd0);
        readReg(3'd1, rd); checkOutput("big_dlo", 64'(rd), 64'h1234_5674);
        readReg(3'd2, rd); checkOutput("big_dhi", 64'(rd), 64'h7);
        readReg(3'd0, rd); checkOutput("wrap_empty", 64'(rd), 64'h2);

        // Reads of an empty FIFO, unmapped addresses, and read-data hold.
        readReg(3'd1, rd); checkOutput("empty_dlo", 64'(rd), 64'd0);
        readReg(3'd2, rd); checkOutput("empty_dhi", 64'(rd), 64'd0);
        readReg(3'd0, rd); checkOutput("empty_status", 64'(rd), 64'h2);
        readReg(3'd4, rd); checkOutput("wincnt_7", 64'(rd), 64'd7);
        readReg(3'd6, rd); checkOutput("unmapped", 64'(rd), 64'd0);
        readReg(3'd4, rd);
        tick();
        checkOutput("rdata_hold", 64'(s_rdata), 64'd7);
        writeClear();
        readReg(3'd4, rd); checkOutput("clear_wincnt", 64'(rd), 64'd0);

        // Overflow: period 1, deltas 1..20, no reads.
        result_in = 36'd0;
        ramp_step = 36'd1;
        ramp_inc  = 36'd1;
        ramp_on   = 1'b1;
        applyStimulus(1'b1, 32'd1);
        for (int i = 0; i < 21; i++) begin
            tick();
        end
        applyStimulus(1'b0, 32'd1);
        tick();
        readReg(3'd0, rd); checkOutput("ovf_status", 64'(rd), 64'h100C);
        readReg(3'd3, rd); checkOutput("ovf_drop", 64'(rd), 64'd4);
        readReg(3'd4, rd); checkOutput("ovf_wincnt", 64'(rd), 64'd20);

        // Pop and push together while full: push accepted, no drop.
        result_in = 36'd0;
        ramp_step = 36'd100;
        ramp_inc  = 36'd0;
        applyStimulus(1'b1, 32'd1);
        tick();
        readReg(3'd2, rd); checkOutput("full_pop_dhi", 64'(rd), 64'd0);
        applyStimulus(1'b0, 32'd1);
        tick();
        readReg(3'd0, rd); checkOutput("full_pp_status", 64'(rd), 64'h100C);
        readReg(3'd3, rd); checkOutput("full_pp_drop", 64'(rd), 64'd4);
        readReg(3'd4, rd); checkOutput("full_pp_wincnt", 64'(rd), 64'd21);
        for (int k = 2; k <= 16; k++) begin
            readReg(3'd1, rd); checkOutput("drain_dlo", 64'(rd), 64'(k));
            readReg(3'd2, rd); checkOutput("drain_dhi", 64'(rd), 64'd0);
        end
        readReg(3'd1, rd); checkOutput("tail_dlo", 64'(rd), 64'd100);
        readReg(3'd2, rd); checkOutput("tail_dhi", 64'(rd), 64'd0);
        readReg(3'd0, rd); checkOutput("sticky_ovf", 64'(rd), 64'hA);

        // Pop at empty coinciding with a push: pop ignored, push lands.
        result_in = 36'd0;
        ramp_step = 36'd5;
        applyStimulus(1'b1, 32'd1);
        tick();
        readReg(3'd2, rd); checkOutput("empty_pp_dhi", 64'(rd), 64'd0);
        applyStimulus(1'b0, 32'd1);
        tick();
        readReg(3'd0, rd); checkOutput("empty_pp_status", 64'(rd), 64'h108);
        readReg(3'd1, rd); checkOutput("empty_pp_dlo", 64'(rd), 64'd5);
        readReg(3'd2, rd);

        // Abort with cnt=2 at period 8, then a clean restart.
        result_in = 36'd1000;
        ramp_step = 36'd1;
        applyStimulus(1'b1, 32'd8);
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        applyStimulus(1'b0, 32'd8);
        readReg(3'd0, rd); checkOutput("abort_pre", 64'(rd), 64'hB);
        readReg(3'd0, rd); checkOutput("abort_idle", 64'(rd), 64'hA);
        ramp_step = 36'd2;
        applyStimulus(1'b1, 32'd8);
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        applyStimulus(1'b0, 32'd8);
        tick();
        readReg(3'd1, rd); checkOutput("restart_dlo", 64'(rd), 64'd16);
        readReg(3'd4, rd); checkOutput("restart_wincnt", 64'(rd), 64'd23);
        readReg(3'd2, rd); checkOutput("restart_dhi", 64'(rd), 64'd0);

        // Asynchronous reset mid-run with 5 entries queued.
        applyStimulus(1'b1, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        readReg(3'd4, rd); checkOutput("pre_reset_wincnt", 64'(rd), 64'd27);
        reset = 1'b1;
        #3;
        checkOutput("async_reset_rdata", 64'(s_rdata), 64'd0);
        applyStimulus(1'b0, 32'd1);
        tick();
        reset = 1'b0;
        readReg(3'd0, rd); checkOutput("post_reset_status", 64'(rd), 64'h2);
        readReg(3'd3, rd); checkOutput("post_reset_drop", 64'(rd), 64'd0);
        readReg(3'd4, rd); checkOutput("post_reset_wincnt", 64'(rd), 64'd0);

        // Clear landing on a window end, with a simultaneous STATUS read.
        applyStimulus(1'b1, 32'd1);
        tick();
        tick();
        s_read  = 1'b1;
        s_addr  = 3'd0;
        s_write = 1'b1;
        s_wdata = 32'd1;
        tick();
        s_read  = 1'b0;
        s_write = 1'b0;
        s_wdata = 32'd0;
        checkOutput("rw_pre_clear", 64'(s_rdata), 64'h101);
        readReg(3'd0, rd); checkOutput("clear_at_end", 64'(rd), 64'h3);
        applyStimulus(1'b0, 32'd1);
        tick();
        readReg(3'd0, rd); checkOutput("after_clear_status", 64'(rd), 64'h100);
        readReg(3'd4, rd); checkOutput("after_clear_wincnt", 64'(rd), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
